// File: rtl/seg7_bin_display.sv
// Multi-digit 7-segment driver. Converts a binary value to decimal (serial
// double-dabble) or hexadecimal digits and registers active-low gfedcba
// segment patterns. A refresh starts only while estado equals SHOW_STATE.
module seg7_bin_display #(
    parameter int                   DATA_W     = 8,
    parameter int                   NUM_DIGITS = 3,
    parameter int                   STATE_W    = 4,
    parameter logic [STATE_W-1:0]   SHOW_STATE = 4'b1100
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [STATE_W-1:0]        estado,
    input  logic [DATA_W-1:0]         value,
    input  logic                      hex_mode,
    input  logic                      lz_blank,
    output logic [7*NUM_DIGITS-1:0]   segs,
    output logic                      busy,
    output logic                      done
);

    localparam int          BCD_W   = 4 * NUM_DIGITS;
    localparam int          CNT_W   = $clog2(DATA_W + 1);
    localparam logic [63:0] DEC_MAX = (64'd10 ** NUM_DIGITS) - 64'd1;
    localparam logic [63:0] HEX_MAX = (64'd1 << BCD_W) - 64'd1;
    localparam logic [6:0]  BLANK   = 7'b1111111;
    localparam logic [6:0]  DASH    = 7'b0111111;

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t             state, state_nxt;
    logic               trig, load;
    logic [DATA_W-1:0]  sh;          // captured value; shifts out MSB-first in decimal mode
    logic [BCD_W-1:0]   bcd, bcd_adj, hexv, digits;
    logic [CNT_W-1:0]   cnt;
    logic               hex_q, lz_q, ovf_q, ovf_nxt;
    logic [7*NUM_DIGITS-1:0] segs_nxt;
    logic [3:0]         d;
    logic               seen;

    function automatic logic [6:0] enc7(input logic [3:0] n);
        case (n)
            4'h0: enc7 = 7'b1000000;
            4'h1: enc7 = 7'b1111001;
            4'h2: enc7 = 7'b0100100;
            4'h3: enc7 = 7'b0110000;
            4'h4: enc7 = 7'b0011001;
            4'h5: enc7 = 7'b0010010;
            4'h6: enc7 = 7'b0000010;
            4'h7: enc7 = 7'b1111000;
            4'h8: enc7 = 7'b0000000;
            4'h9: enc7 = 7'b0010000;
            4'hA: enc7 = 7'b0001000;
            4'hB: enc7 = 7'b0000011;
            4'hC: enc7 = 7'b1000110;
            4'hD: enc7 = 7'b0100001;
            4'hE: enc7 = 7'b0000110;
            default: enc7 = 7'b0001110;
        endcase
    endfunction

    assign trig    = (estado == SHOW_STATE);
    assign ovf_nxt = hex_mode ? (64'(value) > HEX_MAX) : (64'(value) > DEC_MAX);

    // Hex digits come straight from the captured value; digits past its width read as zero.
    if (DATA_W >= BCD_W) begin : gen_hex_wide
        assign hexv = sh[BCD_W-1:0];
    end else begin : gen_hex_pad
        assign hexv = {{(BCD_W-DATA_W){1'b0}}, sh};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: decimal walks through DATA_W conversion steps, hex goes straight to LOAD.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trig) state_nxt = hex_mode ? LOAD : CONV;
            CONV:    if (cnt == CNT_W'(DATA_W - 1)) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state != IDLE);
        load = (state == LOAD);
    end

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    // Capture on trigger, then one conversion step per clock in CONV.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh    <= '0;
            bcd   <= '0;
            cnt   <= '0;
            hex_q <= 1'b0;
            lz_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (trig) begin
                    sh    <= value;
                    bcd   <= '0;
                    cnt   <= '0;
                    hex_q <= hex_mode;
                    lz_q  <= lz_blank;
                    ovf_q <= ovf_nxt;
                end
                CONV: begin
                    bcd <= BCD_W'({bcd_adj, sh[DATA_W-1]});
                    sh  <= sh << 1;
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Segment pattern: dashes on overflow, else digits with optional leading-zero blanking.
    always_comb begin
        digits   = hex_q ? hexv : bcd;
        segs_nxt = '1;
        seen     = 1'b0;
        d        = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            d = digits[4*i +: 4];
            if (d != 4'd0 || i == 0) seen = 1'b1;
            if (ovf_q)              segs_nxt[7*i +: 7] = DASH;
            else if (lz_q && !seen) segs_nxt[7*i +: 7] = BLANK;
            else                    segs_nxt[7*i +: 7] = enc7(d);
        end
    end

    // Output registers: segs update and done pulses on the edge leaving LOAD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            segs <= '1;
            done <= 1'b0;
        end else begin
            done <= load;
            if (load) segs <= segs_nxt;
        end
    end

endmodule
